// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Drives the synchronous-read instruction SRAM and holds the current
// instruction/PC pair for decode. A one-entry buffer keeps the fetched word
// stable across decode back-pressure. A taken branch from decode kills the
// instruction in IF and redirects the fetch in the same cycle.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        resetn,
    // decode side
    input  logic        ID_allow,
    input  logic [32:0] ID_to_IF_bus,
    output logic        IF_to_ID_valid,
    output logic [63:0] IF_to_ID_bus,
    // instruction SRAM side
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // Branch redirect fields from decode.
    logic        br_taken;
    logic [31:0] br_target;

    // Stage state.
    logic        run_reg;
    logic        if_valid_reg;
    logic [31:0] if_pc_reg;
    logic        buf_valid_reg;
    logic [31:0] inst_buf_reg;

    // Combinational fetch control.
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        if_allow;
    logic        fetch_en;
    logic        buf_capture;
    logic [31:0] inst;

    assign br_taken  = ID_to_IF_bus[32];
    assign br_target = ID_to_IF_bus[31:0];

    // Sequential successor wraps naturally at 2^32.
    assign seq_pc = if_pc_reg + 32'd4;

    // The branch target is taken as-is; alignment is the producer's concern.
    assign nextpc = br_taken ? br_target : seq_pc;

    // IF may load a new instruction when it is empty, when decode takes the
    // current one, or when the current one is on the wrong path anyway.
    assign if_allow = !if_valid_reg || ID_allow || br_taken;

    // No fetch until the cycle after reset release, so the first request
    // is made with a settled PC.
    assign fetch_en = run_reg && if_allow;

    // The SRAM word is only valid in the cycle after its request, so a
    // stalled instruction must be copied the first cycle it is blocked.
    assign buf_capture = if_valid_reg && !if_allow && !buf_valid_reg;

    // Once buffered, the SRAM output is ignored (it may be garbage).
    assign inst = buf_valid_reg ? inst_buf_reg : inst_sram_rdata;

    assign inst_sram_en    = fetch_en;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0000_0000;

    // A taken branch squashes whatever IF currently holds.
    assign IF_to_ID_valid = if_valid_reg && !br_taken;
    assign IF_to_ID_bus   = {inst, if_pc_reg};

    // Run flag, PC/valid advance on each request, buffer capture on stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_reg       <= 1'b0;
            if_valid_reg  <= 1'b0;
            if_pc_reg     <= RESET_PC - 32'd4;
            buf_valid_reg <= 1'b0;
            inst_buf_reg  <= 32'h0000_0000;
        end else begin
            run_reg <= 1'b1;
            if (fetch_en) begin
                if_pc_reg     <= nextpc;
                if_valid_reg  <= 1'b1;
                buf_valid_reg <= 1'b0;
            end else if (buf_capture) begin
                inst_buf_reg  <= inst_sram_rdata;
                buf_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of the fetch stage against a transaction-level
// model (which PC is presented, is it live, what must the SRAM see), plus
// hand-computed literal expectations at key points.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk;
    logic        resetn;
    logic        ID_allow;
    logic [32:0] ID_to_IF_bus;
    logic        IF_to_ID_valid;
    logic [63:0] IF_to_ID_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int vectors;
    int miscompares;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ID_allow        (ID_allow),
        .ID_to_IF_bus    (ID_to_IF_bus),
        .IF_to_ID_valid  (IF_to_ID_valid),
        .IF_to_ID_bus    (IF_to_ID_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hdead_beef;
    endfunction

    // Synchronous-read SRAM; data is garbage in any cycle not following a request.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= mem_word(inst_sram_addr);
        else
            inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: whether a live instruction sits in IF, its PC, and whether
    // fetching has begun after reset.
    logic        m_run;
    logic        m_have;
    logic [31:0] m_pc;
    logic        x_en;
    logic [31:0] x_addr;

    // Model advance: a request moves the presented PC to the requested address.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_run  <= 1'b0;
            m_have <= 1'b0;
            m_pc   <= RESET_PC - 32'd4;
        end else begin
            m_run <= 1'b1;
            if (x_en) begin
                m_pc   <= x_addr;
                m_have <= 1'b1;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic        br;
        logic [31:0] tgt;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        br  = ID_to_IF_bus[32];
        tgt = ID_to_IF_bus[31:0];
        if (!resetn) begin
            chk("rst_valid", {63'd0, IF_to_ID_valid}, 64'd0);
            chk("rst_en", {63'd0, inst_sram_en}, 64'd0);
            chk("rst_addr", {32'd0, inst_sram_addr}, {32'd0, RESET_PC});
            x_en   <= 1'b0;
            x_addr <= RESET_PC;
        end else begin
            // Redirect wins; otherwise the next sequential word.
            e_addr  = br ? tgt : m_pc + 32'd4;
            // Fetch when empty, when decode takes the current word, or on redirect.
            e_en    = m_run && (!m_have || ID_allow || br);
            e_valid = m_have && !br;
            $display("cyc t=%0t allow=%0b br=%0b en=%0b addr=%h valid=%0b pc=%h inst=%h",
                     $time, ID_allow, br, inst_sram_en, inst_sram_addr,
                     IF_to_ID_valid, IF_to_ID_bus[31:0], IF_to_ID_bus[63:32]);
            chk("m_en", {63'd0, inst_sram_en}, {63'd0, e_en});
            chk("m_addr", {32'd0, inst_sram_addr}, {32'd0, e_addr});
            chk("m_valid", {63'd0, IF_to_ID_valid}, {63'd0, e_valid});
            if (e_valid)
                chk("m_bus", IF_to_ID_bus, {mem_word(m_pc), m_pc});
            chk("m_we_wdata", {28'd0, inst_sram_we, inst_sram_wdata}, 64'd0);
            x_en   <= e_en;
            x_addr <= e_addr;
        end
    end

    // One cycle of stimulus; returns at the following negedge for literal checks.
    task automatic step(input logic allow, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        ID_allow     = allow;
        ID_to_IF_bus = {br, tgt};
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        resetn          = 1'b0;
        ID_allow        = 1'b1;
        ID_to_IF_bus    = 33'd0;
        inst_sram_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);
        chk("lit_rst_en", {63'd0, inst_sram_en}, 64'd0);

        // Reset release and first fetches.
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("lit_c1_en", {63'd0, inst_sram_en}, 64'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_c2_en", {63'd0, inst_sram_en}, 64'd1);
        chk("lit_c2_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_c3_valid", {63'd0, IF_to_ID_valid}, 64'd1);
        chk("lit_c3_pc", {32'd0, IF_to_ID_bus[31:0]}, 64'h1c00_0000);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_c4_pc", {32'd0, IF_to_ID_bus[31:0]}, 64'h1c00_0004);

        // Three-cycle stall on pc 0x1c000008 with garbage on the SRAM bus.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("lit_stall_en", {63'd0, inst_sram_en}, 64'd0);
            chk("lit_stall_bus", IF_to_ID_bus, 64'hc2ad_bee7_1c00_0008);
        end
        step(1'b1, 1'b0, 32'd0);
        chk("lit_unstall_bus", IF_to_ID_bus, 64'hc2ad_bee7_1c00_0008);
        chk("lit_unstall_addr", {32'd0, inst_sram_addr}, 64'h1c00_000c);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_after_stall_pc", {32'd0, IF_to_ID_bus[31:0]}, 64'h1c00_000c);

        // Straight-line streaming.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'd0);

        // Single-cycle taken branch.
        step(1'b1, 1'b1, 32'h1c00_0100);
        chk("lit_br_valid", {63'd0, IF_to_ID_valid}, 64'd0);
        chk("lit_br_addr", {32'd0, inst_sram_addr}, 64'h1c00_0100);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_br_tgt_bus", IF_to_ID_bus, 64'hc2ad_bfef_1c00_0100);
        chk("lit_br_tgt_valid", {63'd0, IF_to_ID_valid}, 64'd1);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);

        // Branch held three cycles while decode stalls.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h1c00_0100);
            chk("lit_brh_valid", {63'd0, IF_to_ID_valid}, 64'd0);
            chk("lit_brh_addr", {32'd0, inst_sram_addr}, 64'h1c00_0100);
        end
        step(1'b0, 1'b0, 32'd0);
        chk("lit_brh_valid_after", {63'd0, IF_to_ID_valid}, 64'd1);
        chk("lit_brh_pc_after", {32'd0, IF_to_ID_bus[31:0]}, 64'h1c00_0100);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);

        // Wrap past the top of the address space.
        step(1'b1, 1'b1, 32'hffff_fffc);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_wrap_pc", {32'd0, IF_to_ID_bus[31:0]}, 64'hffff_fffc);
        chk("lit_wrap_addr", {32'd0, inst_sram_addr}, 64'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_wrap_bus", IF_to_ID_bus, 64'hdead_beef_0000_0000);
        step(1'b1, 1'b0, 32'd0);

        // Mid-stream reset: outputs must drop without waiting for a clock edge.
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("lit_mrst_valid", {63'd0, IF_to_ID_valid}, 64'd0);
        chk("lit_mrst_en", {63'd0, inst_sram_en}, 64'd0);
        chk("lit_mrst_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("lit_mrst_c1_en", {63'd0, inst_sram_en}, 64'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_mrst_c2_addr", {32'd0, inst_sram_addr}, 64'h1c00_0000);
        step(1'b1, 1'b0, 32'd0);
        chk("lit_mrst_c3_bus", IF_to_ID_bus, 64'hc2ad_beef_1c00_0000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline. It drives the synchronous-read instruction SRAM and holds the fetched instruction/PC pair. It hands that pair to the decode stage over the `IF_to_ID` valid/allow handshake, and accepts branch redirects on the 33-bit `ID_to_IF_bus` that decode produces. It buffers the SRAM read data across decode back-pressure and cancels wrong-path fetches on a taken branch.

## Interface
- `RESET_PC`, default `32'h1c00_0000`: address of the first instruction fetched after reset.
- `clk` input 1: the single clock; every flop is rising-edge.
- `resetn` input 1: asynchronous, active-low reset.
- `ID_allow` input 1: decode can accept a new instruction this cycle.
- `ID_to_IF_bus` input 33: `{br_taken[32], br_target[31:0]}`. Combinational from decode; may stay asserted for several cycles.
- `IF_to_ID_valid` output 1: `IF_to_ID_bus` holds a live instruction.
- `IF_to_ID_bus` output 64: `{inst[63:32], pc[31:0]}`.
- `inst_sram_en` output 1: read request.
- `inst_sram_we` output 4: constant `4'b0`.
- `inst_sram_addr` output 32: request address (`nextpc`).
- `inst_sram_wdata` output 32: constant `32'b0`.
- `inst_sram_rdata` input 32: read data. Valid only in the cycle after a request with `en`=1; undefined otherwise.

## Operation
- State:
  - `run`: 0 during reset, set at the first rising edge after release.
  - `IF_valid`.
  - `IF_pc`, reset to `RESET_PC-4`.
  - `buf_valid`.
  - `inst_buf[31:0]`.
- `seq_pc = IF_pc + 4`, 32-bit, wraps modulo 2^32.
- `nextpc = br_taken ? br_target : seq_pc`. `br_target` is used unmodified; low bits are not checked.
- `IF_allow = !IF_valid || ID_allow || br_taken`.
- `inst_sram_en = run && IF_allow`.
- `inst_sram_addr = nextpc`, driven every cycle.
- On each edge with `inst_sram_en`=1: `IF_pc <= nextpc`, `IF_valid <= 1`, `buf_valid <= 0`.
- On each edge with `run`=1 and `IF_allow`=0: `IF_pc` and `IF_valid` hold.
- Buffer capture: when `IF_valid && !IF_allow && !buf_valid`, `inst_buf <= inst_sram_rdata` and `buf_valid <= 1`.
- `inst = buf_valid ? inst_buf : inst_sram_rdata`.
- `IF_to_ID_valid = IF_valid && !br_taken`. A taken branch kills the instruction currently in IF, which is the wrong path. The instruction at `br_target` is fetched in the same cycle.
- `br_taken` held N cycles while decode stalls: IF re-requests `br_target` every one of those cycles and presents nothing. In the first cycle after `br_taken` drops, IF presents the target instruction.
- `br_taken` and `ID_allow` high in the same cycle: decode latches a bubble (valid=0); the target request is issued.
- `IF_to_ID_bus` is a don't-care when `IF_to_ID_valid`=0.
- No exceptions, no self-modifying-code support, no writes to the instruction SRAM.

## Timing
- Reset values (while `resetn`=0, immediately, asynchronously):
  - `run`=0, `IF_valid`=0, `buf_valid`=0, `IF_pc=RESET_PC-4`.
  - Outputs: `inst_sram_en`=0, `IF_to_ID_valid`=0, `inst_sram_addr=RESET_PC`.
- Release: first edge sets `run`. The next cycle has `en`=1 with `addr=RESET_PC`. One cycle later `IF_to_ID_valid`=1 and `pc=RESET_PC`.
- Fetch latency: request in cycle N → instruction presented in cycle N+1.
- Throughput: 1 instruction/cycle when `ID_allow`=1 continuously.
- Stall: in the first stalled cycle the SRAM data is captured into `inst_buf`. From then on the output comes from the buffer and stays stable until an edge with `IF_allow`=1. No request is issued during a stall.
- A transfer to decode happens on an edge where `IF_to_ID_valid && ID_allow`.
- Reset asserted mid-stream: all state returns to reset values at once. Any in-flight request is discarded, and fetch restarts from `RESET_PC`.

## Test plan
- Reset release, SRAM models sequential words, `ID_allow`=1:
  - cycle 1 after release: `en`=0;
  - cycle 2: `addr=0x1c000000`;
  - cycle 3: valid=1, `pc=0x1c000000`;
  - cycle 4: `pc=0x1c000004`, etc.
- Straight-line: 8 instructions streamed back-to-back → pc increments by 4 each cycle, `inst` equals the SRAM word at pc, no bubbles.
- Stall: `ID_allow`=0 for 3 cycles while `pc=0x1c000008` is presented, SRAM rdata forced to garbage during the stall → `en`=0 all 3 cycles, bus holds `{mem[0x1c000008], 0x1c000008}`. After release the next pc is `0x1c00000c`.
- Taken branch with `br_target=0x1c000100`, one cycle, `ID_allow`=1 → valid=0 in that cycle, `addr=0x1c000100`. Next cycle: valid=1, `pc=0x1c000100`.
- Branch held 3 cycles with `ID_allow`=0 → valid=0 and `addr=0x1c000100` each cycle. After `br_taken` drops: `pc=0x1c000100`, valid=1.
- Wrap and mid-run reset: jump to `0xfffffffc` → next pc `0x00000000`. Then assert `resetn`=0 mid-stream → valid and `en` drop immediately; after release, fetch restarts at `0x1c000000`.
